array_access_ctrl: RTL and testbench
====================================

ARRAY_ACCESS_CTRL -- requirements
Module: array_access_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4, width of the tran_en pulse in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter SETTLE_CYC, default 2, idle cycles after each voltage-assert strobe (legal range 0..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 cmd_read  input  1  1 = read, 0 = write (set/reset).
REQ-007 cmd_addr  input  10  cell address: [9:5] row (BL), [4:0] column (WL/SL).
REQ-008 cmd_vbl, cmd_vwl, cmd_vsl  input  real  BL, WL and SL voltages for the command.
REQ-009 addr_tar  output  10  latched cell address.
REQ-010 read_mode  output  1  latched cmd_read.
REQ-011 bl_assert_en, wl_assert_en, sl_assert_en  output  1 each  one-cycle voltage-valid strobes.
REQ-012 V_BL[32], V_WL[32]  output  real  line voltages.
REQ-013 SL_vol  inout_port32.drive32  SL voltages; SL_current  inout_port32.read32  SL currents returned by the array.
REQ-014 tran_en  output  1  transfer pulse.
REQ-015 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-016 rsp_current[32]  output  real  captured SL currents; busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, DRV_BL, DRV_WL, DRV_SL, PULSE, CLEAR, RESP; a SETTLE_CYC wait SHALL follow each DRV_* strobe cycle.
REQ-018 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready the controller SHALL latch all cmd_* fields, update addr_tar/read_mode on the same edge, and enter DRV_BL.
REQ-019 DRV_BL: V_BL[addr[9:5]]=cmd_vbl, all other V_BL=0.0, bl_assert_en high for exactly one cycle.
REQ-020 DRV_WL, write: V_WL[addr[4:0]]=cmd_vwl, others 0.0; read: all V_WL=0.0; wl_assert_en high for one cycle.
REQ-021 DRV_SL occurs for writes only: all 32 SL_vol.bus32 entries SHALL be cmd_vsl and sl_assert_en SHALL be high for one cycle; reads skip from DRV_WL to PULSE.
REQ-022 PULSE: tran_en SHALL be high for exactly PULSE_CYC consecutive cycles; on reads, SL_current.bus32[0..31] SHALL be captured into rsp_current on the last cycle of the pulse.
REQ-023 Write commands SHALL set rsp_current to all 0.0.
REQ-024 CLEAR: all V_BL, V_WL and SL_vol SHALL be set to 0.0 and bl_assert_en and wl_assert_en strobed together for one cycle, so the array sees zero WL and no further conductance updates occur.
REQ-025 RESP: rsp_valid SHALL be held with stable rsp_current until rsp_ready; the FSM returns to IDLE on the handshake edge, so minimum command-to-command spacing is fixed by the parameters.
REQ-026 Strobes and tran_en SHALL never overlap; tran_en SHALL always be low in IDLE.
REQ-027 cmd_* changes while busy SHALL be ignored.

Reset
REQ-028 While rst_n is low: state IDLE, cmd_ready=0 during reset and 1 from the first clk after release; addr_tar=0, read_mode=0, all strobes=0, tran_en=0, rsp_valid=0, busy=0, all V_BL/V_WL/SL_vol/rsp_current=0.0.
REQ-029 A reset asserted mid-operation, including mid-pulse, SHALL force tran_en low immediately and drop all voltages to 0.0 asynchronously, with no response issued.

Structure
REQ-030 A shared package array_pkg SHALL hold the FSM state enum, N_LINES=32, the address field widths (ROW_W=5, COL_W=5) and the zero-voltage constant.
REQ-031 A single sub-module, access_timer, SHALL provide the loadable down-counter used for both the SETTLE_CYC and PULSE_CYC waits.

Verification
REQ-032 Write cmd_addr=10'h043, vbl=1.0, vwl=1.2, vsl=0.0 -> V_BL[2]=1.0, V_WL[3]=1.2 and all other lines 0.0; tran_en high for 4 cycles; rsp_current all 0.0.
REQ-033 Read cmd_addr=10'h3E0, vbl=0.2 against the array model after reset -> each rsp_current[j]=0.2*1000*0.35=70.0; sl_assert_en never asserted.
REQ-034 rsp_ready held low for 10 cycles -> rsp_valid and rsp_current stable throughout, cmd_ready=0 throughout.
REQ-035 rst_n pulled low during cycle 2 of PULSE -> tran_en=0 and all V_*=0.0 immediately; after release, cmd_ready=1 and no rsp_valid.
REQ-036 Back-to-back write then read to the same cell with cmd_valid held high -> second command accepted only on the first IDLE cycle; the read current reflects the updated conductance.
REQ-037 PULSE_CYC=1, SETTLE_CYC=0 -> tran_en is a single cycle and the strobes occupy consecutive cycles with no overlap.

Source files
------------

// File: rtl/array_access_ctrl_pkg.sv
// Shared types and constants for the crossbar array access controller.
// Latency: none (package only).
// Backpressure: none (package only).
package array_pkg;

    localparam int  N_LINES = 32;
    localparam int  ROW_W   = 5;
    localparam int  COL_W   = 5;
    localparam int  ADDR_W  = ROW_W + COL_W;
    localparam int  TMR_W   = 8;
    localparam real V_ZERO  = 0.0;

    typedef enum logic [2:0] {
        IDLE,
        DRV_BL,
        DRV_WL,
        DRV_SL,
        PULSE,
        CLEAR,
        RESP
    } state_t;

    // Row field selects the bit line
    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:COL_W];
    endfunction

    // Column field selects the word line / source line
    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
        return a[COL_W-1:0];
    endfunction

endpackage

// File: rtl/array_access_ctrl_if.sv
// Command/response bundle and 32-entry analog line bundle for the array controller.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface array_access_ctrl_if;
    import array_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_read;
    logic [ADDR_W-1:0] cmd_addr;
    real               cmd_vbl;
    real               cmd_vwl;
    real               cmd_vsl;
    logic              rsp_valid;
    logic              rsp_ready;
    real               rsp_current [N_LINES];

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_vbl, cmd_vwl, cmd_vsl, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_current
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_vbl, cmd_vwl, cmd_vsl, rsp_ready,
        output cmd_ready, rsp_valid, rsp_current
    );
endinterface

interface inout_port32;
    import array_pkg::*;

    real bus32 [N_LINES];

    modport drive32 (output bus32);
    modport read32  (input  bus32);
endinterface

// File: rtl/array_access_ctrl_timer.sv
// Loadable down-counter shared by the settle and pulse waits.
// Latency: done asserts load_val cycles after the load edge.
// Backpressure: none; a new load always overrides the running count.
module access_timer
    import array_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/array_access_ctrl.sv
// Sequences BL, WL, SL drive, a tran_en pulse and a clear for one crossbar cell access.
// Latency: 3*(1+SETTLE_CYC)+PULSE_CYC+2 cycles accept-to-rsp_valid for writes (reads skip SL).
// Backpressure: cmd_ready only in IDLE; rsp_valid held with stable data until rsp_ready.
module array_access_ctrl
    import array_pkg::*;
#(
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    array_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] addr_tar,
    output logic              read_mode,
    output logic              bl_assert_en,
    output logic              wl_assert_en,
    output logic              sl_assert_en,
    output real               V_BL [N_LINES],
    output real               V_WL [N_LINES],
    inout_port32.drive32      SL_vol,
    inout_port32.read32       SL_current,
    output logic              tran_en,
    output logic              busy
);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);

    state_t           state;
    real              lat_vwl;
    real              lat_vsl;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    access_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Arm the timer on exactly the edges where the FSM enters a timed state
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        case (state)
            IDLE:   tmr_load = bus.cmd_valid && bus.cmd_ready;
            DRV_BL: tmr_load = tmr_done;
            DRV_WL: begin
                tmr_load = tmr_done;
                tmr_val  = read_mode ? PULSE_LD : SETTLE_LD;
            end
            DRV_SL: begin
                tmr_load = tmr_done;
                tmr_val  = PULSE_LD;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    // Access sequencer; every output is registered and reset clears the lines immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            addr_tar      <= '0;
            read_mode     <= 1'b0;
            lat_vwl       <= V_ZERO;
            lat_vsl       <= V_ZERO;
            bl_assert_en  <= 1'b0;
            wl_assert_en  <= 1'b0;
            sl_assert_en  <= 1'b0;
            tran_en       <= 1'b0;
            for (int i = 0; i < N_LINES; i++) begin
                V_BL[i]            <= V_ZERO;
                V_WL[i]            <= V_ZERO;
                SL_vol.bus32[i]    <= V_ZERO;
                bus.rsp_current[i] <= V_ZERO;
            end
        end else begin
            bl_assert_en <= 1'b0;
            wl_assert_en <= 1'b0;
            sl_assert_en <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        addr_tar      <= bus.cmd_addr;
                        read_mode     <= bus.cmd_read;
                        lat_vwl       <= bus.cmd_vwl;
                        lat_vsl       <= bus.cmd_vsl;
                        for (int i = 0; i < N_LINES; i++) begin
                            V_BL[i] <= (i == int'(addr_row(bus.cmd_addr))) ? bus.cmd_vbl : V_ZERO;
                        end
                        bl_assert_en <= 1'b1;
                        state        <= DRV_BL;
                    end
                end
                DRV_BL: begin
                    if (tmr_done) begin
                        // Reads keep every WL at zero so the cell is sensed, not programmed
                        for (int i = 0; i < N_LINES; i++) begin
                            V_WL[i] <= (!read_mode && (i == int'(addr_col(addr_tar)))) ? lat_vwl : V_ZERO;
                        end
                        wl_assert_en <= 1'b1;
                        state        <= DRV_WL;
                    end
                end
                DRV_WL: begin
                    if (tmr_done) begin
                        if (read_mode) begin
                            tran_en <= 1'b1;
                            state   <= PULSE;
                        end else begin
                            for (int i = 0; i < N_LINES; i++) begin
                                SL_vol.bus32[i] <= lat_vsl;
                            end
                            sl_assert_en <= 1'b1;
                            state        <= DRV_SL;
                        end
                    end
                end
                DRV_SL: begin
                    if (tmr_done) begin
                        tran_en <= 1'b1;
                        state   <= PULSE;
                    end
                end
                PULSE: begin
                    if (tmr_done) begin
                        // Last pulse cycle: sample currents, then zero every line
                        tran_en <= 1'b0;
                        for (int i = 0; i < N_LINES; i++) begin
                            bus.rsp_current[i] <= read_mode ? SL_current.bus32[i] : V_ZERO;
                            V_BL[i]            <= V_ZERO;
                            V_WL[i]            <= V_ZERO;
                            SL_vol.bus32[i]    <= V_ZERO;
                        end
                        bl_assert_en <= 1'b1;
                        wl_assert_en <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_array_access_ctrl.sv
// Directed bench for array_access_ctrl with a crossbar conductance model and response scoreboard.
// Latency: n/a (testbench).
// Backpressure: rsp_ready is throttled by the directed steps.
module tb_array_access_ctrl;
    import array_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main DUT (default timing)
    array_access_ctrl_if bus_if ();
    inout_port32         sl_vol_if ();
    inout_port32         sl_cur_if ();
    logic [ADDR_W-1:0]   addr_tar;
    logic                read_mode, bl_en, wl_en, sl_en, tran_en, busy;
    real                 v_bl [N_LINES];
    real                 v_wl [N_LINES];

    array_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .addr_tar     (addr_tar),
        .read_mode    (read_mode),
        .bl_assert_en (bl_en),
        .wl_assert_en (wl_en),
        .sl_assert_en (sl_en),
        .V_BL         (v_bl),
        .V_WL         (v_wl),
        .SL_vol       (sl_vol_if),
        .SL_current   (sl_cur_if),
        .tran_en      (tran_en),
        .busy         (busy)
    );

    // Fast DUT (single-cycle pulse, no settle)
    array_access_ctrl_if bus1_if ();
    inout_port32         sl_vol1_if ();
    inout_port32         sl_cur1_if ();
    logic [ADDR_W-1:0]   addr_tar1;
    logic                read_mode1, bl1, wl1, sl1, tran1, busy1;
    real                 v_bl1 [N_LINES];
    real                 v_wl1 [N_LINES];

    array_access_ctrl #(.PULSE_CYC(1), .SETTLE_CYC(0)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus1_if),
        .addr_tar     (addr_tar1),
        .read_mode    (read_mode1),
        .bl_assert_en (bl1),
        .wl_assert_en (wl1),
        .sl_assert_en (sl1),
        .V_BL         (v_bl1),
        .V_WL         (v_wl1),
        .SL_vol       (sl_vol1_if),
        .SL_current   (sl_cur1_if),
        .tran_en      (tran1),
        .busy         (busy1)
    );

    real g [N_LINES*N_LINES] = '{default: 0.35};
    real exp_q [$];
    int  sl_seen  = 0;
    int  run_len  = 0;
    int  last_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit close(input real a, input real b);
        return ((a - b) < 1.0e-6) && ((b - a) < 1.0e-6);
    endfunction

    task automatic chk_r(input string tag, input real obs, input real exp);
        checks++;
        assert (close(obs, exp)) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    // True when exactly BL[row]=vb, WL[col]=vw, every SL=vs and all other lines are zero
    function automatic bit lines_match(input int row, input real vb, input int col, input real vw, input real vs);
        bit ok = 1'b1;
        for (int i = 0; i < N_LINES; i++) begin
            if (!close(v_bl[i], (i == row) ? vb : 0.0)) ok = 1'b0;
            if (!close(v_wl[i], (i == col) ? vw : 0.0)) ok = 1'b0;
            if (!close(sl_vol_if.bus32[i], vs)) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic push_exp(input real base, input int col, input real colval);
        for (int j = 0; j < N_LINES; j++) exp_q.push_back((j == col) ? colval : base);
    endtask

    task automatic issue(input logic rd, input logic [ADDR_W-1:0] a, input real vb, input real vw, input real vs);
        int k = 0;
        bus_if.cmd_read  = rd;
        bus_if.cmd_addr  = a;
        bus_if.cmd_vbl   = vb;
        bus_if.cmd_vwl   = vw;
        bus_if.cmd_vsl   = vs;
        bus_if.cmd_valid = 1'b1;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus_if.cmd_valid = 1'b0;
        chk("accept", busy, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    // Array model: program cells while pulsing, then drive SL currents; plus protocol and scoreboard monitor
    always @(negedge clk) begin : mon
        real acc;
        if (tran_en) begin
            for (int r = 0; r < N_LINES; r++)
                for (int c = 0; c < N_LINES; c++)
                    if (((v_bl[r] - sl_vol_if.bus32[c]) > 0.5) && (v_wl[c] > 0.5))
                        g[r*N_LINES+c] = g[r*N_LINES+c] + 0.01;
        end
        for (int j = 0; j < N_LINES; j++) begin
            acc = 0.0;
            for (int r = 0; r < N_LINES; r++) acc = acc + v_bl[r] * g[r*N_LINES+j] * 1000.0;
            sl_cur_if.bus32[j] = acc;
        end
        if (sl_en) sl_seen++;
        if (tran_en) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (tran_en || bl_en || wl_en || sl_en)
            chk("no_overlap", tran_en && (bl_en || wl_en || sl_en), 1'b0);
        if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            chk("sb_expected", exp_q.size() >= N_LINES, 1'b1);
            if (exp_q.size() >= N_LINES)
                for (int j = 0; j < N_LINES; j++) chk_r("rsp_current", bus_if.rsp_current[j], exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          sl_base;
        bit          same;
        logic [3:0]  seq;
        logic [3:0]  exp_seq [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0000};

        bus_if.cmd_valid  = 1'b0; bus_if.cmd_read  = 1'b0; bus_if.cmd_addr  = '0;
        bus_if.cmd_vbl    = 0.0;  bus_if.cmd_vwl   = 0.0;  bus_if.cmd_vsl   = 0.0;
        bus_if.rsp_ready  = 1'b0;
        bus1_if.cmd_valid = 1'b0; bus1_if.cmd_read = 1'b0; bus1_if.cmd_addr = '0;
        bus1_if.cmd_vbl   = 0.0;  bus1_if.cmd_vwl  = 0.0;  bus1_if.cmd_vsl  = 0.0;
        bus1_if.rsp_ready = 1'b0;
        for (int j = 0; j < N_LINES; j++) sl_cur1_if.bus32[j] = 0.0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus_if.cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tran_en", tran_en, 1'b0);
        chk("rst_strobes", {bl_en, wl_en, sl_en}, 3'b000);
        chk("rst_addr_tar", addr_tar, 10'h000);
        chk("rst_read_mode", read_mode, 1'b0);
        chk("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        chk("rst_lines", lines_match(-1, 0.0, -1, 0.0, 0.0), 1'b1);
        chk_r("rst_rsp_current", bus_if.rsp_current[7], 0.0);
        chk("rst1_addr_mode", {addr_tar1, read_mode1}, 11'h000);
        chk_r("rst1_lines", v_bl1[0] + v_wl1[31] + sl_vol1_if.bus32[4], 0.0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus_if.cmd_ready, 1'b1);

        // Read row 31 against the fresh array: every SL sees 0.2 V * 0.35 mS
        bus_if.rsp_ready = 1'b1;
        sl_base = sl_seen;
        push_exp(70.0, -1, 0.0);
        issue(1'b1, 10'h3E0, 0.2, 0.0, 0.0);
        chk("read_latch", {read_mode, addr_tar}, {1'b1, 10'h3E0});
        wait_idle();
        chk("read_no_sl_strobe", sl_seen - sl_base, 0);
        chk("read_pulse_len", last_run, 4);

        // Write cell (2,3) with the response held off for 10 cycles
        bus_if.rsp_ready = 1'b0;
        push_exp(0.0, -1, 0.0);
        issue(1'b0, 10'h043, 1.0, 1.2, 0.0);
        bus_if.cmd_read = 1'b1;
        bus_if.cmd_addr = 10'h3FF;
        k = 0;
        while (!tran_en && k < 50) begin @(negedge clk); k++; end
        chk("write_tran_seen", tran_en, 1'b1);
        chk("write_lines", lines_match(2, 1.0, 3, 1.2, 0.0), 1'b1);
        chk_r("write_vbl2", v_bl[2], 1.0);
        chk_r("write_vwl3", v_wl[3], 1.2);
        chk("busy_ignores_cmd", {read_mode, addr_tar}, {1'b0, 10'h043});
        k = 0;
        while (!bus_if.rsp_valid && k < 50) begin @(negedge clk); k++; end
        for (int n = 0; n < 10; n++) begin
            chk("hold_rsp_valid", bus_if.rsp_valid, 1'b1);
            chk("hold_cmd_ready", bus_if.cmd_ready, 1'b0);
            same = (exp_q.size() >= N_LINES);
            for (int j = 0; j < N_LINES && same; j++) if (!close(bus_if.rsp_current[j], exp_q[j])) same = 1'b0;
            chk("hold_rsp_stable", same, 1'b1);
            @(negedge clk);
        end
        chk("write_pulse_len", last_run, 4);
        @(posedge clk);
        #1 bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        wait_idle();

        // Back-to-back write then read of cell (31,0) with cmd_valid held high
        push_exp(0.0, -1, 0.0);
        issue(1'b0, 10'h3E0, 1.0, 1.2, 0.0);
        bus_if.cmd_read  = 1'b1;
        bus_if.cmd_vbl   = 0.2;
        bus_if.cmd_vwl   = 0.0;
        bus_if.cmd_valid = 1'b1;
        push_exp(70.0, 0, 78.0);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        chk("b2b_first_idle_ready", {busy, bus_if.cmd_ready}, 2'b01);
        @(negedge clk);
        chk("b2b_second_accept", {busy, read_mode}, 2'b11);
        bus_if.cmd_valid = 1'b0;
        wait_idle();

        // Reset during cycle 2 of the write pulse
        issue(1'b0, 10'h043, 1.0, 1.2, 0.0);
        k = 0;
        while (!tran_en && k < 50) begin @(negedge clk); k++; end
        chk("abort_tran_seen", tran_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tran_en", tran_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_lines", lines_match(-1, 0.0, -1, 0.0, 0.0), 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_cmd_ready", bus_if.cmd_ready, 1'b1);
        chk("abort_no_rsp", bus_if.rsp_valid, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        // Fast instance: strobes and the one-cycle pulse on consecutive cycles
        bus1_if.cmd_read  = 1'b0;
        bus1_if.cmd_addr  = 10'h043;
        bus1_if.cmd_vbl   = 1.0;
        bus1_if.cmd_vwl   = 1.2;
        bus1_if.cmd_vsl   = 0.0;
        bus1_if.rsp_ready = 1'b1;
        bus1_if.cmd_valid = 1'b1;
        k = 0;
        while (!busy1 && k < 50) begin @(negedge clk); k++; end
        bus1_if.cmd_valid = 1'b0;
        chk("fast_accept", busy1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            seq = {bl1, wl1, sl1, tran1};
            chk("fast_sequence", seq, exp_seq[n]);
            @(negedge clk);
        end
        chk("fast_done", {busy1, bus1_if.rsp_valid}, 2'b00);
        chk_r("fast_rsp_current", bus1_if.rsp_current[3], 0.0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
